// File: rtl/shared_counter_rr_scheduler.sv
// Round-robin scheduler that lends one shared modulo up-counter to N_REQ
// requesters, one timed interval at a time, with completion and abort handling.
module shared_counter_rr_scheduler #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 4
) (
  input  logic                     C,
  input  logic                     CLR,
  input  logic [N_REQ-1:0]         REQ,
  input  logic [N_REQ*CNT_W-1:0]   LEN,
  output logic [N_REQ-1:0]         GNT,
  output logic [N_REQ-1:0]         DONE,
  output logic                     BUSY,
  output logic [CNT_W-1:0]         Q
);

  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t             state_q;
  logic [N_REQ-1:0]   gnt_q;
  logic [N_REQ-1:0]   done_q;
  logic               busy_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   len_q;
  logic [IDX_W-1:0]   last_q;
  logic [IDX_W-1:0]   win_q;

  logic [IDX_W-1:0]   pick_d;
  logic [IDX_W-1:0]   cand_d;
  logic [N_REQ-1:0]   onehot_d;
  logic [CNT_W-1:0]   lenSel_d;
  logic               terminal_d;
  int                 idx;

  // Walk from the farthest candidate to the nearest so the requester right
  // after last_q is the final (and therefore winning) assignment.
  always_comb begin
    pick_d = last_q;
    cand_d = '0;
    idx    = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = int'(last_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand_d = IDX_W'(idx);
      if (REQ[cand_d]) pick_d = cand_d;
    end
  end

  always_comb begin
    onehot_d         = '0;
    onehot_d[pick_d] = 1'b1;
    lenSel_d         = LEN[pick_d*CNT_W +: CNT_W];
  end

  // A stored length of zero wraps to all-ones here, giving a full 2**CNT_W run.
  assign terminal_d = (cnt_q == len_q - CNT_W'(1));

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
      win_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= '0;
          if (|REQ) begin
            gnt_q   <= onehot_d;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            len_q   <= lenSel_d;
            win_q   <= pick_d;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (terminal_d) begin
            done_q  <= gnt_q;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            last_q  <= win_q;
            state_q <= IDLE;
          end else if (!REQ[win_q]) begin
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            last_q  <= win_q;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign GNT  = gnt_q;
  assign DONE = done_q;
  assign BUSY = busy_q;
  assign Q    = cnt_q;

endmodule

// File: tb/tb_shared_counter_rr_scheduler.sv
// Scoreboard bench: stimulus queues expected grants, a monitor checks each
// grant's one-hot vector, Q sequence, length and the DONE pulse that follows.
module tb_shared_counter_rr_scheduler;

  logic        C = 1'b0;
  logic        CLR;
  logic [3:0]  REQ;
  logic [15:0] LEN;
  logic [3:0]  GNT;
  logic [3:0]  DONE;
  logic        BUSY;
  logic [3:0]  Q;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] gnt;
    int         len;
    logic [3:0] done;
  } exp_t;

  exp_t expQ[$];

  shared_counter_rr_scheduler #(.N_REQ(4), .CNT_W(4)) dut (
    .C(C), .CLR(CLR), .REQ(REQ), .LEN(LEN),
    .GNT(GNT), .DONE(DONE), .BUSY(BUSY), .Q(Q)
  );

  always #5 C = ~C;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pushExpect(input logic [3:0] g, input int len, input logic [3:0] d);
    exp_t e;
    e.gnt  = g;
    e.len  = len;
    e.done = d;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [3:0] req);
    REQ = req;
  endtask

  task automatic waitQ(input logic [3:0] g, input logic [3:0] q);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge C);
      if (GNT == g && Q == q) seen = 1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("[TB] FAIL waitQ timeout: got GNT=%0h Q=%0d expected GNT=%0h Q=%0d", GNT, Q, g, q);
    end
  endtask

  task automatic waitDone(input logic [3:0] d);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge C);
      if (DONE == d) seen = 1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("[TB] FAIL waitDone timeout: got DONE=%0h expected %0h", DONE, d);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, ".GNT"}, 32'(GNT), 32'h0);
    checkOutput({tag, ".DONE"}, 32'(DONE), 32'h0);
    checkOutput({tag, ".BUSY"}, 32'(BUSY), 32'h0);
    checkOutput({tag, ".Q"}, 32'(Q), 32'h0);
  endtask

  // Monitor: pops one expectation per grant and follows it to its DONE slot.
  initial begin
    bit   active   = 0;
    bit   pulseChk = 0;
    int   cyc      = 0;
    exp_t cur;
    cur.gnt  = '0;
    cur.len  = 0;
    cur.done = '0;
    forever begin
      @(negedge C);
      if (GNT != 4'b0) begin
        if (!active) begin
          if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpectedGrant: got GNT=%0h expected none", GNT);
            cur.gnt  = GNT;
            cur.len  = 0;
            cur.done = '0;
          end else begin
            cur = expQ.pop_front();
          end
          active = 1;
          cyc    = 0;
        end
        if (pulseChk) pulseChk = 0;
        checkOutput("gnt", 32'(GNT), 32'(cur.gnt));
        checkOutput("q", 32'(Q), 32'(cyc));
        checkOutput("busyRun", 32'(BUSY), 32'h1);
        checkOutput("doneInRun", 32'(DONE), 32'h0);
        cyc++;
      end else if (active) begin
        checkOutput("grantLen", 32'(cyc), 32'(cur.len));
        checkOutput("donePulse", 32'(DONE), 32'(cur.done));
        checkOutput("busyIdle", 32'(BUSY), 32'h0);
        checkOutput("qIdle", 32'(Q), 32'h0);
        active   = 0;
        pulseChk = 1;
      end else if (pulseChk) begin
        checkOutput("doneWidth", 32'(DONE), 32'h0);
        pulseChk = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;

    // Reset held with all requesters asking: nothing may be granted.
    CLR = 1'b1;
    LEN = 16'h1111;
    applyStimulus(4'b1111);
    repeat (3) begin
      @(negedge C);
      checkIdleOutputs("reset");
    end

    // Round-robin after reset starts at requester 0.
    pushExpect(4'b0001, 1, 4'b0001);
    pushExpect(4'b0010, 1, 4'b0010);
    pushExpect(4'b0100, 1, 4'b0100);
    pushExpect(4'b1000, 1, 4'b1000);
    pushExpect(4'b0001, 1, 4'b0001);
    CLR = 1'b0;
    n = 0;
    for (int i = 0; i < 60 && n < 5; i++) begin
      @(negedge C);
      if (GNT != 4'b0) n++;
      if (n == 5) applyStimulus(4'b0000);
    end
    if (n != 5) begin
      total++;
      bad++;
      $display("[TB] FAIL rrTimeout: got %0d grants expected 5", n);
      applyStimulus(4'b0000);
    end
    repeat (3) @(negedge C);

    // Single 3-cycle interval; a LEN change mid-run must be ignored.
    pushExpect(4'b0001, 3, 4'b0001);
    LEN[3:0] = 4'd3;
    applyStimulus(4'b0001);
    waitQ(4'b0001, 4'd1);
    LEN[3:0] = 4'd7;
    waitDone(4'b0001);
    applyStimulus(4'b0000);
    repeat (3) @(negedge C);

    // LEN=0 gives a full 16-cycle interval.
    pushExpect(4'b0100, 16, 4'b0100);
    LEN[11:8] = 4'd0;
    applyStimulus(4'b0100);
    waitDone(4'b0100);
    applyStimulus(4'b0000);
    repeat (3) @(negedge C);

    // Abort of requester 2, then requester 3 drops REQ on its terminal edge.
    CLR = 1'b1;
    @(negedge C);
    CLR = 1'b0;
    LEN = 16'h5555;
    pushExpect(4'b0100, 2, 4'b0000);
    pushExpect(4'b1000, 5, 4'b1000);
    applyStimulus(4'b1100);
    waitQ(4'b0100, 4'd1);
    applyStimulus(4'b1000);
    waitQ(4'b1000, 4'd4);
    applyStimulus(4'b0000);
    repeat (4) @(negedge C);

    // Asynchronous reset in the middle of an 8-cycle interval.
    CLR = 1'b1;
    @(negedge C);
    CLR = 1'b0;
    LEN[7:4] = 4'd8;
    pushExpect(4'b0010, 6, 4'b0000);
    applyStimulus(4'b0010);
    waitQ(4'b0010, 4'd5);
    #2;
    CLR = 1'b1;
    #1;
    checkIdleOutputs("asyncReset");
    LEN[3:0] = 4'd2;
    LEN[7:4] = 4'd2;
    applyStimulus(4'b0011);
    pushExpect(4'b0001, 2, 4'b0001);
    pushExpect(4'b0010, 2, 4'b0010);
    @(negedge C);
    @(negedge C);
    CLR = 1'b0;
    waitDone(4'b0010);
    applyStimulus(4'b0000);
    repeat (4) @(negedge C);

    checkOutput("queueEmpty", 32'(expQ.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
